// File: rtl/hamming74_pkg.sv
// Shared Hamming(7,4) definitions: FSM states, codeword bit map and the encoder function.
// The receive-side decoder uses the same bit map, so keep the two in step.
package hamming74_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D0 = 2;
  localparam int P4 = 3;
  localparam int D1 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;

  function automatic logic [6:0] hamming74_encode(input logic [3:0] nib);
    logic [6:0] cw;
    cw     = '0;
    cw[D0] = nib[0];
    cw[D1] = nib[1];
    cw[D2] = nib[2];
    cw[D3] = nib[3];
    cw[P1] = nib[0] ^ nib[1] ^ nib[3];
    cw[P2] = nib[0] ^ nib[2] ^ nib[3];
    cw[P4] = nib[1] ^ nib[2] ^ nib[3];
    return cw;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, DEPTH a power of two; a pop shows the next entry one cycle later.
// Pushes while full and pops while empty are ignored; full/empty come straight from the count register.
module sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset: entries are only visible once the count covers them.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/hamming74_encoder_tx.sv
// Buffers {inject_pos,nibble}, Hamming(7,4)-encodes and holds each codeword HOLD_CYCLES, then GAP_CYCLES idle.
// Output updates one edge after a push into an empty idle block; data_ready=!full gives backpressure.
module hamming74_encoder_tx
  import hamming74_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [3:0]  data_in,
  input  logic [2:0]  inject_pos,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [6:0]  io_out,
  output logic [6:0]  io_oeb,
  output logic        cw_valid,
  output logic [15:0] tx_count
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [6:0]         io_out_q, io_out_d;
  logic               cw_valid_q, cw_valid_d;
  logic [15:0]        tx_count_q, tx_count_d;

  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [6:0]         head_dat;
  logic [2:0]         head_inj;
  logic [6:0]         inj_mask;
  logic [6:0]         launch_cw;
  logic               launch;

  assign data_ready = !fifo_full;
  assign fifo_push  = data_valid && data_ready;

  sync_fifo #(
    .WIDTH (7),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .push_i     (fifo_push),
    .push_dat_i ({inject_pos, data_in}),
    .pop_i      (fifo_pop),
    .pop_dat_o  (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign head_inj  = head_dat[6:4];
  assign inj_mask  = (head_inj == 3'd0) ? 7'd0 : (7'd1 << (head_inj - 3'd1));
  assign launch_cw = hamming74_encode(head_dat[3:0]) ^ inj_mask;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    io_out_d   = io_out_q;
    cw_valid_d = cw_valid_q;
    tx_count_d = tx_count_q;
    launch     = 1'b0;
    case (state_q)
      IDLE: begin
        cw_valid_d = 1'b0;
        launch     = !fifo_empty;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          cw_valid_d = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LD;
          end else if (!fifo_empty) begin
            launch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) launch = 1'b1;
          else             state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A launch overrides whatever the state branch chose for this edge.
    if (launch) begin
      state_d    = HOLD;
      cnt_d      = HOLD_LD;
      io_out_d   = launch_cw;
      cw_valid_d = 1'b1;
      tx_count_d = tx_count_q + 16'd1;
    end
  end

  assign fifo_pop = launch;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      io_out_q   <= '0;
      cw_valid_q <= 1'b0;
      tx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      io_out_q   <= io_out_d;
      cw_valid_q <= cw_valid_d;
      tx_count_q <= tx_count_d;
    end
  end

  assign io_out   = io_out_q;
  assign io_oeb   = 7'b0;
  assign cw_valid = cw_valid_q;
  assign tx_count = tx_count_q;

endmodule

// File: tb/tb_hamming74_encoder_tx.sv
// Bench for hamming74_encoder_tx: two DUT lanes (GAP=1 and GAP=0) with a scoreboard of codewords and launch cycles.
module tb_hamming74_encoder_tx;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0] cw;
    int         launch;
  } exp_t;

  // Classic Hamming layout: parity at positions 1,2,4, data at 3,5,6,7; io_out bit k = position k+1.
  function automatic logic [6:0] ref_cw(input logic [3:0] d, input logic [2:0] inj);
    logic [7:1] pos;
    logic [6:0] cw;
    logic       p;
    int         dpos [4];
    dpos = '{3, 5, 6, 7};
    pos  = '0;
    for (int i = 0; i < 4; i++) pos[dpos[i]] = d[i];
    for (int j = 0; j < 3; j++) begin
      p = 1'b0;
      for (int k = 1; k <= 7; k++)
        if (((k >> j) & 1) == 1 && k != (1 << j)) p = p ^ pos[k];
      pos[1 << j] = p;
    end
    cw = pos[7:1];
    if (inj != 3'd0) cw[inj - 3'd1] = ~cw[inj - 3'd1];
    return cw;
  endfunction

  task automatic chk(input string nm, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, act, req);
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LGAP = (g == 0) ? 1 : 0;
    localparam int PER  = HOLD + LGAP;

    logic [3:0]  din = '0;
    logic [2:0]  inj = '0;
    logic        dv  = 1'b0;
    logic        rdy;
    logic [6:0]  io, oeb;
    logic        cwv;
    logic [15:0] txc;

    hamming74_encoder_tx #(
      .DEPTH       (DEPTH),
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (LGAP)
    ) u_dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .data_in    (din),
      .inject_pos (inj),
      .data_valid (dv),
      .data_ready (rdy),
      .io_out     (io),
      .io_oeb     (oeb),
      .cw_valid   (cwv),
      .tx_count   (txc)
    );

    exp_t        q[$];
    int          last_sched  = -1000;
    int          last_launch = -1000;
    logic [6:0]  exp_io      = '0;
    logic [15:0] last_tx     = '0;
    int          run = 0;
    int          max_run = 0;

    always @(negedge clk) begin
      exp_t e;
      if (rst) begin
        q.delete();
        last_sched  = -1000;
        last_launch = -1000;
        exp_io      = '0;
        last_tx     = '0;
        run         = 0;
      end else begin
        if (txc != last_tx) begin
          chk("tx_count_step", txc, last_tx + 16'd1);
          chk("launch_expected", q.size(), (q.size() > 0) ? q.size() : 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("cw_value", io, e.cw);
            chk("launch_cycle", cyc, e.launch);
            exp_io = e.cw;
          end
          last_launch = cyc;
          last_tx     = txc;
        end
        chk("cw_valid", cwv, (cyc - last_launch) < HOLD);
        chk("io_out_hold", io, exp_io);
        chk("data_ready", rdy, q.size() < DEPTH);
        run = cwv ? run + 1 : 0;
        if (run > max_run) max_run = run;
      end
    end

    task automatic send(input logic [3:0] d, input logic [2:0] i);
      int waited;
      int t;
      waited = 0;
      @(negedge clk);
      #1;
      dv  = 1'b1;
      din = d;
      inj = i;
      while (!rdy && waited < 50) begin
        @(negedge clk);
        #1;
        waited++;
      end
      if (!rdy) begin
        chk("ready_timeout", rdy, 1);
        dv = 1'b0;
      end else begin
        // Accepted at the coming edge (cyc+1); launches one edge later unless the previous slot is busy.
        t = (cyc + 2 > last_sched + PER) ? cyc + 2 : last_sched + PER;
        last_sched = t;
        q.push_back('{ref_cw(d, i), t});
      end
    endtask

    task automatic idle(input int n);
      @(negedge clk);
      #1;
      dv = 1'b0;
      repeat (n) @(negedge clk);
    endtask

    task automatic drain();
      int b;
      b = 0;
      while ((q.size() != 0 || cwv) && b < 300) begin
        @(negedge clk);
        b++;
      end
      repeat (PER + 1) @(negedge clk);
      chk("drain", q.size(), 0);
    endtask
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    #12;
    chk("rst_io_out", lane[0].io, 0);
    chk("rst_cw_valid", lane[0].cwv, 0);
    chk("rst_tx_count", lane[0].txc, 0);
    chk("rst_io_oeb", lane[0].oeb, 0);
    chk("rst_ready", lane[0].rdy, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;

    lane[0].send(4'b1011, 3'd0);
    lane[0].idle(1);
    chk("first_cw_direct", lane[0].io, 7'b1010101);
    lane[0].drain();
    chk("first_tx_count", lane[0].txc, 1);
    chk("first_run_len", lane[0].max_run, HOLD);

    lane[0].send(4'h0, 3'd0);
    lane[0].send(4'h1, 3'd0);
    lane[0].send(4'h8, 3'd0);
    lane[0].send(4'hF, 3'd0);
    lane[0].idle(1);
    lane[0].drain();

    lane[0].send(4'h8, 3'd4);
    lane[0].idle(1);
    chk("inject_cw_direct", lane[0].io, 7'b1000011);
    lane[0].drain();

    for (int i = 0; i < 10; i++) lane[0].send(4'($urandom_range(15)), 3'd0);
    lane[0].idle(1);
    lane[0].drain();

    for (int i = 0; i < 40; i++) begin
      lane[0].send(4'($urandom_range(15)), 3'($urandom_range(7)));
      if ($urandom_range(3) == 0) lane[0].idle($urandom_range(1, 7));
    end
    lane[0].idle(1);
    lane[0].drain();
    chk("tx_count_total", lane[0].txc, 56);

    for (int i = 0; i < 4; i++) lane[0].send(4'($urandom_range(15)), 3'd0);
    lane[0].idle(0);
    #2;
    chk("pre_rst_cw_valid", lane[0].cwv, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_io_out", lane[0].io, 0);
    chk("async_rst_cw_valid", lane[0].cwv, 0);
    chk("async_rst_tx_count", lane[0].txc, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_no_stale", lane[0].txc, 0);
    lane[0].send(4'h6, 3'd0);
    lane[0].idle(1);
    lane[0].drain();
    chk("post_rst_tx_count", lane[0].txc, 1);

    lane[1].send(4'h5, 3'd0);
    lane[1].send(4'hA, 3'd0);
    lane[1].idle(1);
    lane[1].drain();
    chk("gap0_run_len", lane[1].max_run, 2 * HOLD);

    for (int i = 0; i < 20; i++) begin
      lane[1].send(4'($urandom_range(15)), 3'($urandom_range(7)));
      if ($urandom_range(3) == 0) lane[1].idle($urandom_range(1, 9));
    end
    lane[1].idle(1);
    lane[1].drain();
    chk("gap0_tx_count", lane[1].txc, 22);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
